// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared types and constants for the seven-segment scan driver
package seg7_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      COMMIT
   } conv_state_t;

   // Active-low {g,f,e,d,c,b,a} patterns for digits 0-9
   localparam logic [6:0] SEG_LUT [0:9] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
      7'h12, 7'h02, 7'h78, 7'h00, 7'h10
   };

   localparam logic [6:0]  SEG_BLANK = 7'h7F;
   localparam logic [13:0] MAX_VAL   = 14'd9999;

   function automatic logic [6:0] seg_decode(input logic [3:0] nib);
      logic [6:0] pat;
      pat = SEG_BLANK;
      if (nib <= 4'd9) begin
         pat = SEG_LUT[nib];
      end
      return pat;
   endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// rtl/seg7_scan_driver_if.sv - value/load/scan-clock inputs and display outputs of the scan driver
interface seg7_scan_driver_if #(
   parameter int BIN_W      = 14,
   parameter int NUM_DIGITS = 4
);
   logic                  sclk;
   logic [BIN_W-1:0]      value;
   logic                  load;
   logic                  busy;
   logic [6:0]            seg;
   logic                  dp;
   logic [NUM_DIGITS-1:0] an;

   modport master (output sclk, value, load, input busy, seg, dp, an);
   modport slave  (input sclk, value, load, output busy, seg, dp, an);
endinterface

// File: rtl/seg7_scan_driver_bin2bcd_dd.sv
// rtl/seg7_scan_driver_bin2bcd_dd.sv - iterative double-dabble binary-to-BCD converter with saturation
module bin2bcd_dd
   import seg7_pkg::*;
#(
   parameter int BIN_W = 14
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load_i,
   input  logic [BIN_W-1:0] value_i,
   output logic             busy_o,
   output logic [15:0]      bcd_o,
   output logic [15:0]      bcd_nxt_o
);

   conv_state_t      state_q, state_d;
   logic [BIN_W-1:0] bin_q, bin_d;
   logic [15:0]      bcd_q, bcd_d;
   logic [15:0]      out_q, out_d;
   logic [3:0]       cnt_q, cnt_d;
   logic [15:0]      adj;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         bin_q   <= '0;
         bcd_q   <= '0;
         out_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         bin_q   <= bin_d;
         bcd_q   <= bcd_d;
         out_q   <= out_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      bin_d   = bin_q;
      bcd_d   = bcd_q;
      out_d   = out_q;
      cnt_d   = cnt_q;
      adj     = bcd_q;
      for (int i = 0; i < 4; i++) begin
         if (bcd_q[4*i +: 4] >= 4'd5) begin
            adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
         end
      end
      case (state_q)
         IDLE: begin
            if (load_i) begin
               bin_d   = (value_i > MAX_VAL) ? MAX_VAL : value_i;
               bcd_d   = '0;
               cnt_d   = '0;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            // Top adjusted bit is always 0 for inputs up to 9999
            {bcd_d, bin_d} = {adj[14:0], bin_q, 1'b0};
            cnt_d          = cnt_q + 4'd1;
            if (cnt_q == 4'd13) begin
               state_d = COMMIT;
            end
         end
         COMMIT: begin
            out_d   = bcd_q;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign busy_o    = (state_q != IDLE);
   assign bcd_o     = out_q;
   assign bcd_nxt_o = out_d;

endmodule

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - 4-digit common-anode scan driver; optional LEADING_ZERO_BLANK_EN blanks leading zeros
module seg7_scan_driver
   import seg7_pkg::*;
#(
   parameter int NUM_DIGITS = 4,
   parameter int BIN_W      = 14
) (
   input  logic               clk,
   input  logic               reset,
   seg7_scan_driver_if.slave  bus
);

   logic                  sync1_q, sync2_q, hist_q;
   logic                  scan_edge;
   logic [1:0]            idx_q, idx_d;
   logic [NUM_DIGITS-1:0] an_q, an_d;
   logic [6:0]            seg_q, seg_d;
   logic                  busy;
   logic [15:0]           bcd;
   logic [15:0]           bcd_nxt;

   bin2bcd_dd #(.BIN_W(BIN_W)) u_conv (
      .clk       (clk),
      .reset     (reset),
      .load_i    (bus.load),
      .value_i   (bus.value),
      .busy_o    (busy),
      .bcd_o     (bcd),
      .bcd_nxt_o (bcd_nxt)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         hist_q  <= 1'b0;
         idx_q   <= '0;
         an_q    <= ~NUM_DIGITS'(1);
         seg_q   <= 7'b1000000;
      end else begin
         sync1_q <= bus.sclk;
         sync2_q <= sync1_q;
         hist_q  <= sync2_q;
         idx_q   <= idx_d;
         an_q    <= an_d;
         seg_q   <= seg_d;
      end
   end

   assign scan_edge = sync2_q & ~hist_q;

   // Decode from the next display value so a commit shows without waiting for a scan edge
`ifdef LEADING_ZERO_BLANK_EN
   logic [3:0] lz;
   always_comb begin
      lz    = '0;
      lz[3] = (bcd_nxt[15:12] == 4'd0);
      lz[2] = lz[3] & (bcd_nxt[11:8] == 4'd0);
      lz[1] = lz[2] & (bcd_nxt[7:4] == 4'd0);
   end
`endif

   always_comb begin
      idx_d = scan_edge ? idx_q + 2'd1 : idx_q;
      an_d  = ~(NUM_DIGITS'(1) << idx_d);
      seg_d = seg_decode(bcd_nxt[4*idx_d +: 4]);
`ifdef LEADING_ZERO_BLANK_EN
      if (lz[idx_d]) begin
         seg_d = SEG_BLANK;
      end
`else
`endif
   end

   assign bus.busy = busy;
   assign bus.an   = an_q;
   assign bus.seg  = seg_q;
   assign bus.dp   = 1'b1;

endmodule
